// File: rtl/booth_div_pkg.sv
// Shared types and helpers for the booth_div signed divider.
// BOOTH_DIV_RADIX4_EN selects two quotient bits per iteration instead of one.
package booth_div_pkg;

    localparam int XW_DEF = 33;
    localparam int PW_DEF = 65;
    localparam int MAX_W  = 128;

`ifdef BOOTH_DIV_RADIX4_EN
    localparam int RADIX_BITS = 2;
`else
    localparam int RADIX_BITS = 1;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic int iter_steps(input int xw);
        return (xw + RADIX_BITS - 1) / RADIX_BITS;
    endfunction

    localparam int ITER_STEPS = iter_steps(XW_DEF);

    // Two's-complement negate when neg is set; also serves as |x| given the sign bit.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic neg);
        logic [MAX_W-1:0] res;
        if (neg) begin
            res = ~v + MAX_W'(1);
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/booth_div_step.sv
// One combinational restoring division step on magnitudes.
// BOOTH_DIV_RADIX4_EN: compares against d, 2d, 3d and retires two quotient bits.
module booth_div_step
    import booth_div_pkg::*;
#(
    parameter int XW = XW_DEF
) (
    input  logic [XW:0]            i_prem,
    input  logic [XW-1:0]          i_dsr,
    input  logic [RADIX_BITS-1:0]  i_bits,
    output logic [XW:0]            o_prem,
    output logic [RADIX_BITS-1:0]  o_q
);

    localparam int EW = XW + 3;

    logic [EW-1:0] w_sh;
    logic [EW-1:0] w_d1;
    logic [EW-1:0] w_rem;

    assign w_sh = (EW'(i_prem) << RADIX_BITS) | EW'(i_bits);
    assign w_d1 = EW'(i_dsr);

`ifdef BOOTH_DIV_RADIX4_EN
    logic [EW-1:0] w_d2;
    logic [EW-1:0] w_d3;

    assign w_d2 = w_d1 << 1;
    assign w_d3 = w_d1 + w_d2;

    // Largest multiple of d not exceeding the shifted remainder.
    always_comb begin
        w_rem = w_sh;
        o_q   = 2'b00;
        if (w_sh >= w_d3) begin
            w_rem = w_sh - w_d3;
            o_q   = 2'b11;
        end else if (w_sh >= w_d2) begin
            w_rem = w_sh - w_d2;
            o_q   = 2'b10;
        end else if (w_sh >= w_d1) begin
            w_rem = w_sh - w_d1;
            o_q   = 2'b01;
        end else begin
            w_rem = w_sh;
            o_q   = 2'b00;
        end
    end
`else
    // Subtract d when it fits, otherwise restore.
    always_comb begin
        w_rem = w_sh;
        o_q   = 1'b0;
        if (w_sh >= w_d1) begin
            w_rem = w_sh - w_d1;
            o_q   = 1'b1;
        end else begin
            w_rem = w_sh;
            o_q   = 1'b0;
        end
    end
`endif

    assign o_prem = (XW+1)'(w_rem);

endmodule

// File: rtl/booth_div.sv
// Sequential signed divider (PW-bit dividend / XW-bit divisor) with start/busy/done.
// BOOTH_DIV_RADIX4_EN selects the radix-4 iteration; results are identical in both builds.
module booth_div
    import booth_div_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int PW = PW_DEF   // must be 2*XW-1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [PW-1:0] dividend,
    input  logic [XW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] quotient,
    output logic [XW-1:0] remainder,
    output logic          div0,
    output logic          ovf
);

    localparam int STEPS = iter_steps(XW);
    localparam int LO_W  = STEPS * RADIX_BITS;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [XW-1:0] Q_NEG_LIM = {1'b1, {(XW-1){1'b0}}};

    state_t                r_state;
    logic [PW-1:0]         r_dvd;
    logic [XW-1:0]         r_dsr;
    logic [XW:0]           r_prem;
    logic [LO_W-1:0]       r_lo;
    logic [CW-1:0]         r_cnt;
    logic                  r_e_div0;
    logic                  r_e_ovf;
    logic                  r_busy;
    logic                  r_done;
    logic [XW-1:0]         r_quo;
    logic [XW-1:0]         r_rem;
    logic                  r_div0;
    logic                  r_ovf;

    logic [PW-1:0]         w_dvd_mag;
    logic [XW-1:0]         w_dsr_mag;
    logic                  w_hi_ovf;
    logic [XW:0]           w_step_prem;
    logic [RADIX_BITS-1:0] w_step_q;
    logic                  w_neg_q;
    logic [XW-1:0]         w_q_mag;
    logic                  w_q_ovf;
    logic [XW-1:0]         w_q_signed;
    logic [XW-1:0]         w_r_signed;

    assign w_dvd_mag = PW'(cond_neg(MAX_W'(r_dvd), r_dvd[PW-1]));
    assign w_dsr_mag = XW'(cond_neg(MAX_W'(r_dsr), r_dsr[XW-1]));
    // Quotient needs more than XW unsigned bits when the top dividend half reaches |divisor|.
    assign w_hi_ovf  = ({1'b0, w_dvd_mag[PW-1:XW]} >= w_dsr_mag);

    booth_div_step #(.XW(XW)) u_step (
        .i_prem (r_prem),
        .i_dsr  (w_dsr_mag),
        .i_bits (r_lo[LO_W-1 -: RADIX_BITS]),
        .o_prem (w_step_prem),
        .o_q    (w_step_q)
    );

    assign w_neg_q    = r_dvd[PW-1] ^ r_dsr[XW-1];
    assign w_q_mag    = r_lo[XW-1:0];
    assign w_q_ovf    = w_neg_q ? (w_q_mag > Q_NEG_LIM) : w_q_mag[XW-1];
    assign w_q_signed = XW'(cond_neg(MAX_W'(w_q_mag), w_neg_q));
    assign w_r_signed = XW'(cond_neg(MAX_W'(r_prem[XW-1:0]), r_dvd[PW-1]));

    // Control FSM, iterative datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_dvd    <= {PW{1'b0}};
            r_dsr    <= {XW{1'b0}};
            r_prem   <= {(XW+1){1'b0}};
            r_lo     <= {LO_W{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_e_div0 <= 1'b0;
            r_e_ovf  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_quo    <= {XW{1'b0}};
            r_rem    <= {XW{1'b0}};
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_dvd   <= dividend;
                        r_dsr   <= divisor;
                        r_busy  <= 1'b1;
                        r_state <= PREP;
                    end
                end
                PREP: begin
                    r_prem <= (XW+1)'(w_dvd_mag[PW-1:LO_W]);
                    r_lo   <= w_dvd_mag[LO_W-1:0];
                    r_cnt  <= {CW{1'b0}};
                    if (w_dsr_mag == {XW{1'b0}}) begin
                        r_e_div0 <= 1'b1;
                        r_e_ovf  <= 1'b1;
                        r_state  <= FIX;
                    end else if (w_hi_ovf) begin
                        r_e_div0 <= 1'b0;
                        r_e_ovf  <= 1'b1;
                        r_state  <= FIX;
                    end else begin
                        r_e_div0 <= 1'b0;
                        r_e_ovf  <= 1'b0;
                        r_state  <= ITER;
                    end
                end
                ITER: begin
                    r_prem <= w_step_prem;
                    r_lo   <= {r_lo[LO_W-RADIX_BITS-1:0], w_step_q};
                    if (r_cnt == CW'(STEPS - 1)) begin
                        r_cnt   <= {CW{1'b0}};
                        r_state <= FIX;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                FIX: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                    if (r_e_ovf || w_q_ovf) begin
                        r_quo  <= {XW{1'b0}};
                        r_rem  <= {XW{1'b0}};
                        r_div0 <= r_e_div0;
                        r_ovf  <= 1'b1;
                    end else begin
                        r_quo  <= w_q_signed;
                        r_rem  <= w_r_signed;
                        r_div0 <= 1'b0;
                        r_ovf  <= 1'b0;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quo;
    assign remainder = r_rem;
    assign div0      = r_div0;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_booth_div.sv
// Self-checking bench for booth_div: directed cases, handshake, reset and random
// operands checked against a wide-integer reference model.
module tb_booth_div;

`ifdef BOOTH_DIV_RADIX4_EN
    localparam int NSTEP = 17;
`else
    localparam int NSTEP = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [64:0] dividend = 65'd0;
    logic [32:0] divisor = 33'd0;
    logic        busy, done, div0, ovf;
    logic [32:0] quotient, remainder;

    int n_checks = 0;
    int n_errors = 0;

    booth_div dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div0      (div0),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact signed division on 128-bit integers.
    task automatic model(input logic [64:0] a, input logic [32:0] b,
                         output logic [32:0] eq, output logic [32:0] er,
                         output logic ediv0, output logic eovf, output int elat);
        logic signed [127:0] sa, sb, q, r, ma, mb;
        sa = {{63{a[64]}}, a};
        sb = {{95{b[32]}}, b};
        ediv0 = 1'b0; eovf = 1'b0; elat = NSTEP + 2; q = 128'sd0; r = 128'sd0;
        if (sb == 128'sd0) begin
            ediv0 = 1'b1; eovf = 1'b1; elat = 2;
        end else begin
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            q = sa / sb;
            r = sa % sb;
            if ((ma >> 33) >= mb) elat = 2;
            if (q > 128'sd4294967295 || q < -128'sd4294967296) begin
                eovf = 1'b1; q = 128'sd0; r = 128'sd0;
            end
        end
        eq = q[32:0];
        er = r[32:0];
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_result(input string name, input logic [64:0] a, input logic [32:0] b, input int lat);
        logic [32:0] eq, er;
        logic ed, eo;
        int el;
        model(a, b, eq, er, ed, eo, el);
        chk({name, ".lat"}, 128'(lat), 128'(el));
        chk({name, ".quo"}, 128'(quotient), 128'(eq));
        chk({name, ".rem"}, 128'(remainder), 128'(er));
        chk({name, ".div0"}, 128'(div0), 128'(ed));
        chk({name, ".ovf"}, 128'(ovf), 128'(eo));
    endtask

    task automatic run_div(input string name, input logic [64:0] a, input logic [32:0] b);
        int lat;
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, ".busy"}, 128'(busy), 128'(1'b1));
        wait_done(lat);
        check_result(name, a, b, lat);
        @(posedge clk); #1;
        chk({name, ".pulse"}, 128'(done), 128'(1'b0));
    endtask

    initial begin
        int lat, cnt;
        logic [95:0] t, u;
        logic [64:0] ra;
        logic [32:0] rb;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 128'(busy), 128'(1'b0));
        chk("rst.done", 128'(done), 128'(1'b0));
        chk("rst.quo", 128'(quotient), 128'(33'd0));
        chk("rst.rem", 128'(remainder), 128'(33'd0));
        chk("rst.flags", 128'({div0, ovf}), 128'(2'b00));
        @(negedge clk);
        rst_n = 1'b1;

        run_div("p_p", 65'd100, 33'd7);
        chk("p_p.q14", 128'(quotient), 128'(33'd14));
        run_div("n_p", -65'sd100, 33'd7);
        run_div("p_n", 65'd100, -33'sd7);
        run_div("n_n", -65'sd100, -33'sd7);
        run_div("div0", 65'h1_2345_6789, 33'd0);
        run_div("ovf40", 65'h100_0000_0000, 33'd1);
        run_div("min_pos", 65'h1_8000_0000_0000_0000, 33'h0_8000_0000);
        run_div("min_neg", 65'h1_8000_0000_0000_0000, 33'h1_8000_0000);
        run_div("dmin", 65'h1_0000_0000_0000_0000, 33'h1_0000_0000);
        run_div("qmax", 65'h0_7FFF_FFFF_0000_0000, 33'h0_8000_0000);

        // Start held high; a second operand set shows up while busy.
        @(negedge clk);
        dividend = 65'd1000; divisor = 33'd9; start = 1'b1;
        @(posedge clk); #1;
        chk("hs.busy0", 128'(busy), 128'(1'b1));
        dividend = -65'sd5000; divisor = 33'd13;
        wait_done(lat);
        check_result("hs.first", 65'd1000, 33'd9, lat);
        @(posedge clk); #1;
        chk("hs.done_cycle", 128'({busy, done}), 128'(2'b00));
        @(posedge clk); #1;
        chk("hs.reaccept", 128'(busy), 128'(1'b1));
        wait_done(lat);
        start = 1'b0;
        check_result("hs.second", -65'sd5000, 33'd13, lat);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (busy || done) cnt++;
        end
        chk("hs.no_extra", 128'(cnt), 128'(0));

        // Reset in the middle of an iteration.
        @(negedge clk);
        dividend = 65'd12345; divisor = 33'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst.busy_done", 128'({busy, done}), 128'(2'b00));
        chk("mrst.quo", 128'(quotient), 128'(33'd0));
        chk("mrst.rem", 128'(remainder), 128'(33'd0));
        chk("mrst.flags", 128'({div0, ovf}), 128'(2'b00));
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done || busy) cnt++;
        end
        chk("mrst.no_done", 128'(cnt), 128'(0));
        run_div("mrst.fresh", 65'd100, 33'd7);

        for (int k = 0; k < 40; k++) begin
            t = {$urandom(), $urandom(), $urandom()};
            u = {$urandom(), $urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0: begin ra = t[64:0];                    rb = u[32:0]; end
                1: begin ra = {{17{t[47]}}, t[47:0]};     rb = u[32:0]; end
                2: begin ra = {{1{t[63]}}, t[63:0]};      rb = u[32:0]; end
                default: begin ra = {{15{t[49]}}, t[49:0]}; rb = {{13{u[19]}}, u[19:0]}; end
            endcase
            if ($urandom_range(0, 15) == 0) rb = 33'd0;
            run_div($sformatf("rnd%0d", k), ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
